// File: rtl/data_unpacker_pw.sv
// Word-to-lane serializer: one OUT_WIDTH lane per cycle into a byte FIFO.
// Supports backpressure, partial words, lane order and bubble-free chaining.
module data_unpacker_pw #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int LANES     = IN_WIDTH / OUT_WIDTH,
  parameter int LANE_W    = $clog2(LANES),
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_pll,
  input  logic                 reset_n,
  input  logic [IN_WIDTH-1:0]  data,
  input  logic                 data_valid,
  input  logic [LANE_W-1:0]    data_lanes,
  input  logic                 msb_first,
  output logic                 data_ready,
  input  logic                 FIFO_full,
  output logic [OUT_WIDTH-1:0] FIFO_input_data,
  output logic                 FIFO_push_data,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] lane_count
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IN_WIDTH-1:0]  r_hold;
  logic [LANE_W-1:0]    r_idx;
  logic [LANE_W:0]      r_rem;
  logic                 r_msb;
  logic [OUT_WIDTH-1:0] r_out;
  logic                 r_push;
  logic                 r_busy;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [OUT_WIDTH-1:0] w_lane [LANES];
  logic                 w_last;
  logic                 w_adv;
  logic                 w_acc;
  logic [LANE_W:0]      w_rem_init;
  logic [LANE_W-1:0]    w_start;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane[g] = r_hold[g*OUT_WIDTH +: OUT_WIDTH];
  end

  assign w_last = (r_rem == (LANE_W+1)'(1));
  assign w_adv  = (r_state == EMIT) && !FIFO_full;
  assign data_ready = (r_state == IDLE) || (w_adv && w_last);
  assign w_acc  = data_valid && data_ready;

  // A lane count of zero means the whole word.
  assign w_rem_init = (data_lanes == '0)
                    ? (LANE_W+1)'(LANES)
                    : {1'b0, data_lanes};
  assign w_start = msb_first ? LANE_W'(LANES-1) : '0;

  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (data_valid) begin
          w_next = EMIT;
        end
      end
      EMIT: begin
        if (w_adv && w_last && !data_valid) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= '0;
      r_idx  <= '0;
      r_rem  <= '0;
      r_msb  <= 1'b0;
      r_out  <= '0;
      r_push <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_adv) begin
        r_out  <= w_lane[r_idx];
        r_push <= 1'b1;
        r_cnt  <= r_cnt + CNT_WIDTH'(1);
        r_idx  <= r_msb ? r_idx - LANE_W'(1)
                        : r_idx + LANE_W'(1);
        r_rem  <= r_rem - (LANE_W+1)'(1);
      end
      // A word loaded on the last-lane edge overrides the step.
      if (w_acc) begin
        r_hold <= data;
        r_rem  <= w_rem_init;
        r_msb  <= msb_first;
        r_idx  <= w_start;
      end
      r_busy <= (w_next == EMIT);
    end
  end

  assign FIFO_input_data = r_out;
  assign FIFO_push_data  = r_push;
  assign busy            = r_busy;
  assign lane_count      = r_cnt;

endmodule

// File: tb/tb_data_unpacker_pw.sv
// Directed bench for data_unpacker_pw on a 32/8 build.
// A second instance with a 4-bit counter exercises counter wrap.
module tb_data_unpacker_pw;

  logic        clk_pll = 1'b0;
  logic        reset_n;
  logic [31:0] data;
  logic        data_valid;
  logic [1:0]  data_lanes;
  logic        msb_first;
  logic        data_ready;
  logic        FIFO_full;
  logic [7:0]  FIFO_input_data;
  logic        FIFO_push_data;
  logic        busy;
  logic [15:0] lane_count;

  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_push;
  logic        s_busy;
  logic [3:0]  s_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_pll = ~clk_pll;

  data_unpacker_pw dut (
    .clk_pll(clk_pll),
    .reset_n(reset_n),
    .data(data),
    .data_valid(data_valid),
    .data_lanes(data_lanes),
    .msb_first(msb_first),
    .data_ready(data_ready),
    .FIFO_full(FIFO_full),
    .FIFO_input_data(FIFO_input_data),
    .FIFO_push_data(FIFO_push_data),
    .busy(busy),
    .lane_count(lane_count)
  );

  data_unpacker_pw #(.CNT_WIDTH(4)) dut_s (
    .clk_pll(clk_pll),
    .reset_n(reset_n),
    .data(data),
    .data_valid(data_valid),
    .data_lanes(data_lanes),
    .msb_first(msb_first),
    .data_ready(s_ready),
    .FIFO_full(FIFO_full),
    .FIFO_input_data(s_data),
    .FIFO_push_data(s_push),
    .busy(s_busy),
    .lane_count(s_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pll);
    #1;
  endtask

  task automatic exp_push(input string tag, input logic [7:0] b);
    chk({tag, " push"}, 32'(FIFO_push_data), 32'd1);
    chk({tag, " data"}, 32'(FIFO_input_data), 32'(b));
  endtask

  task automatic exp_nopush(input string tag);
    chk({tag, " nopush"}, 32'(FIFO_push_data), 32'd0);
  endtask

  task automatic send(input logic [31:0] w,
                      input logic [1:0] ln,
                      input logic msb);
    data       = w;
    data_lanes = ln;
    msb_first  = msb;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    data       = 32'hDEADBEEF;
    data_lanes = 2'd1;
    msb_first  = ~msb;
  endtask

  initial begin
    reset_n    = 1'b0;
    data       = '0;
    data_valid = 1'b0;
    data_lanes = '0;
    msb_first  = 1'b0;
    FIFO_full  = 1'b0;
    #12;
    chk("rst push", 32'(FIFO_push_data), 32'd0);
    chk("rst data", 32'(FIFO_input_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cnt", 32'(lane_count), 32'd0);
    chk("rst ready", 32'(data_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // single word, lsb first
    send(32'hA1B2C3D4, 2'd0, 1'b0);
    chk("t1 busy0", 32'(busy), 32'd1);
    exp_nopush("t1 e0");
    chk("t1 rdy0", 32'(data_ready), 32'd0);
    tick(); exp_push("t1 l0", 8'hD4);
    chk("t1 rdy1", 32'(data_ready), 32'd0);
    tick(); exp_push("t1 l1", 8'hC3);
    tick(); exp_push("t1 l2", 8'hB2);
    chk("t1 rdy3", 32'(data_ready), 32'd1);
    tick(); exp_push("t1 l3", 8'hA1);
    chk("t1 cnt", 32'(lane_count), 32'd4);
    chk("t1 busy", 32'(busy), 32'd0);
    chk("t1 rdy", 32'(data_ready), 32'd1);
    tick(); exp_nopush("t1 idle");
    chk("t1 hold", 32'(FIFO_input_data), 32'hA1);

    // msb first
    send(32'hA1B2C3D4, 2'd0, 1'b1);
    tick(); exp_push("t2 l0", 8'hA1);
    tick(); exp_push("t2 l1", 8'hB2);
    tick(); exp_push("t2 l2", 8'hC3);
    tick(); exp_push("t2 l3", 8'hD4);
    chk("t2 cnt", 32'(lane_count), 32'd8);

    // back-to-back, valid held high
    data       = 32'h03020100;
    data_lanes = 2'd0;
    msb_first  = 1'b0;
    data_valid = 1'b1;
    tick();
    data = 32'h07060504;
    tick(); exp_push("t3 l0", 8'h00);
    chk("t3 rdy0", 32'(data_ready), 32'd0);
    tick(); exp_push("t3 l1", 8'h01);
    chk("t3 rdy1", 32'(data_ready), 32'd0);
    tick(); exp_push("t3 l2", 8'h02);
    chk("t3 rdy2", 32'(data_ready), 32'd1);
    tick(); exp_push("t3 l3", 8'h03);
    chk("t3 busy", 32'(busy), 32'd1);
    data_valid = 1'b0;
    data       = 32'hFFFFFFFF;
    tick(); exp_push("t3 l4", 8'h04);
    tick(); exp_push("t3 l5", 8'h05);
    tick(); exp_push("t3 l6", 8'h06);
    chk("t3 s15", 32'(s_cnt), 32'd15);
    tick(); exp_push("t3 l7", 8'h07);
    chk("t3 cnt", 32'(lane_count), 32'd16);
    chk("t3 swrap", 32'(s_cnt), 32'd0);
    chk("t3 busy end", 32'(busy), 32'd0);

    // backpressure after second lane
    send(32'h44332211, 2'd0, 1'b0);
    tick(); exp_push("t4 l0", 8'h11);
    tick(); exp_push("t4 l1", 8'h22);
    FIFO_full = 1'b1;
    #1;
    chk("t4 rdy full", 32'(data_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); exp_nopush($sformatf("t4 stall%0d", i));
      chk("t4 stall busy", 32'(busy), 32'd1);
    end
    chk("t4 stall data", 32'(FIFO_input_data), 32'h22);
    chk("t4 stall cnt", 32'(lane_count), 32'd18);
    FIFO_full = 1'b0;
    tick(); exp_push("t4 l2", 8'h33);
    tick(); exp_push("t4 l3", 8'h44);
    chk("t4 cnt", 32'(lane_count), 32'd20);
    tick(); exp_nopush("t4 idle");

    // partial words
    send(32'h11223344, 2'd3, 1'b0);
    tick(); exp_push("t5 l0", 8'h44);
    tick(); exp_push("t5 l1", 8'h33);
    tick(); exp_push("t5 l2", 8'h22);
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 cnt", 32'(lane_count), 32'd23);
    tick(); exp_nopush("t5 idle");
    send(32'hA1B2C3D4, 2'd2, 1'b1);
    tick(); exp_push("t5b l0", 8'hA1);
    tick(); exp_push("t5b l1", 8'hB2);
    chk("t5b cnt", 32'(lane_count), 32'd25);
    tick(); exp_nopush("t5b idle");
    chk("t5b busy", 32'(busy), 32'd0);

    // async reset mid-word
    send(32'h55667788, 2'd0, 1'b0);
    tick(); exp_push("t6 l0", 8'h88);
    tick(); exp_push("t6 l1", 8'h77);
    #2 reset_n = 1'b0;
    #1;
    chk("t6 push", 32'(FIFO_push_data), 32'd0);
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 cnt", 32'(lane_count), 32'd0);
    chk("t6 data", 32'(FIFO_input_data), 32'd0);
    chk("t6 scnt", 32'(s_cnt), 32'd0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); exp_nopush($sformatf("t6 post%0d", i));
      chk("t6 post cnt", 32'(lane_count), 32'd0);
    end
    send(32'h000000C5, 2'd1, 1'b0);
    tick(); exp_push("t6 new", 8'hC5);
    chk("t6 new cnt", 32'(lane_count), 32'd1);
    tick(); exp_nopush("t6 end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
